spi_response_arbiter: RTL and testbench

SPI_RESPONSE_ARBITER -- requirements
Module: spi_response_arbiter

---
 rtl/spi_response_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_response_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_response_arbiter.sv
// SPI response arbiter: serves an opcode from the lowest-indexed claiming
// responder, answers the status opcode internally, and returns a fixed idle
// byte if no responder claims the opcode within the timeout window.
module spi_response_arbiter #(
    parameter int unsigned NUM_RESPONDERS = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  IDLE_RESPONSE  = 8'hFF,
    parameter logic [7:0]  STATUS_ADDRESS = 8'hDF
) (
    input  logic                          clock_in,
    input  logic                          reset_n_in,
    input  logic [7:0]                    opcode_in,
    input  logic                          opcode_valid_in,
    input  logic [NUM_RESPONDERS*8-1:0]   response_in,
    input  logic [NUM_RESPONDERS-1:0]     response_valid_in,
    output logic [7:0]                    response_out,
    output logic                          response_valid_out,
    output logic                          conflict_out,
    output logic                          timeout_out
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WIN_W   = 3;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_valid_q;
    logic [CNT_W-1:0]    r_counter;
    logic [WIN_W-1:0]    r_last_winner;
    logic                r_conflict;
    logic                r_timeout;
    logic [BYTE_W-1:0]   r_response;
    logic                r_response_valid;

    state_t              w_state;
    logic                w_valid_q;
    logic [CNT_W-1:0]    w_counter;
    logic [WIN_W-1:0]    w_last_winner;
    logic                w_conflict;
    logic                w_timeout;
    logic [BYTE_W-1:0]   w_response;
    logic                w_response_valid;

    logic                w_start;
    logic                w_any;
    logic                w_multi;
    logic [WIN_W-1:0]    w_win_idx;
    logic [BYTE_W-1:0]   w_win_data;

    assign w_start = opcode_valid_in & ~r_valid_q;
    assign w_any   = |response_valid_in;
    // Clearing the lowest set bit leaves something only if two or more claim.
    assign w_multi = |(response_valid_in & (response_valid_in - NUM_RESPONDERS'(1)));

    // Priority encoder: descending scan so the lowest-indexed claimant wins.
    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        for (int i = int'(NUM_RESPONDERS) - 1; i >= 0; i--) begin
            if (response_valid_in[i]) begin
                w_win_idx  = WIN_W'(i);
                w_win_data = response_in[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/HOLD sequencer.
    always_comb begin
        w_state          = r_state;
        w_valid_q        = opcode_valid_in;
        w_counter        = r_counter;
        w_last_winner    = r_last_winner;
        w_conflict       = r_conflict;
        w_timeout        = r_timeout;
        w_response       = r_response;
        w_response_valid = r_response_valid;

        case (r_state)
            ST_IDLE: begin
                w_response       = '0;
                w_response_valid = 1'b0;
                if (w_start) begin
                    if (opcode_in == STATUS_ADDRESS) begin
                        w_response       = {r_conflict, r_timeout, 3'b000, r_last_winner};
                        w_response_valid = 1'b1;
                        w_conflict       = 1'b0;
                        w_timeout        = 1'b0;
                        w_state          = ST_HOLD;
                    end else begin
                        w_counter = '0;
                        w_state   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!opcode_valid_in) begin
                    w_state = ST_IDLE;
                end else if (w_any) begin
                    w_response       = w_win_data;
                    w_response_valid = 1'b1;
                    w_last_winner    = w_win_idx;
                    if (w_multi) begin
                        w_conflict = 1'b1;
                    end
                    w_state = ST_HOLD;
                end else if (r_counter == TIMEOUT_LAST) begin
                    w_response       = IDLE_RESPONSE;
                    w_response_valid = 1'b1;
                    w_timeout        = 1'b1;
                    w_state          = ST_HOLD;
                end else if (r_counter != CNT_MAX) begin
                    w_counter = r_counter + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!opcode_valid_in) begin
                    w_response       = '0;
                    w_response_valid = 1'b0;
                    w_state          = ST_IDLE;
                end
            end
            default: begin
                w_response       = '0;
                w_response_valid = 1'b0;
                w_state          = ST_IDLE;
            end
        endcase
    end

    // State and output registers; valid_q resets high so a live transaction
    // at reset release is not mistaken for a fresh start.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state          <= ST_IDLE;
            r_valid_q        <= 1'b1;
            r_counter        <= '0;
            r_last_winner    <= '0;
            r_conflict       <= 1'b0;
            r_timeout        <= 1'b0;
            r_response       <= '0;
            r_response_valid <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_valid_q        <= w_valid_q;
            r_counter        <= w_counter;
            r_last_winner    <= w_last_winner;
            r_conflict       <= w_conflict;
            r_timeout        <= w_timeout;
            r_response       <= w_response;
            r_response_valid <= w_response_valid;
        end
    end

    assign response_out       = r_response;
    assign response_valid_out = r_response_valid;
    assign conflict_out       = r_conflict;
    assign timeout_out        = r_timeout;

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Self-checking bench for spi_response_arbiter with a transaction-level model.
module tb_spi_response_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 64;
    localparam int NONE = 1000;

    logic              clk;
    logic              rst_n;
    logic [7:0]        opcode_in;
    logic              opcode_valid_in;
    logic [NR*8-1:0]   response_in;
    logic [NR-1:0]     response_valid_in;
    logic [7:0]        response_out;
    logic              response_valid_out;
    logic              conflict_out;
    logic              timeout_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model of the sticky status.
    logic       m_conflict = 1'b0;
    logic       m_timeout  = 1'b0;
    logic [2:0] m_winner   = 3'd0;

    spi_response_arbiter #(
        .NUM_RESPONDERS (NR),
        .TIMEOUT_CYCLES (TMO),
        .IDLE_RESPONSE  (8'hFF),
        .STATUS_ADDRESS (8'hDF)
    ) dut (
        .clock_in           (clk),
        .reset_n_in         (rst_n),
        .opcode_in          (opcode_in),
        .opcode_valid_in    (opcode_valid_in),
        .response_in        (response_in),
        .response_valid_in  (response_valid_in),
        .response_out       (response_out),
        .response_valid_out (response_valid_out),
        .conflict_out       (conflict_out),
        .timeout_out        (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_conflict = 1'b0;
        m_timeout  = 1'b0;
        m_winner   = 3'd0;
    endtask

    // One opcode transaction; responders claim with mask after d WAIT cycles
    // (d >= TMO means nobody claims).
    task automatic run_txn(input string name, input logic [7:0] op, input int d,
                           input logic [NR-1:0] mask, input logic [NR*8-1:0] data);
        logic [7:0] exp_byte;
        int         win;
        int         last_k;
        bit         early;
        bit         hold_bad;
        if (d < TMO) begin
            win = -1;
            for (int i = 0; i < NR; i++) if (mask[i] && win < 0) win = i;
            exp_byte = data[8*win +: 8];
            if ($countones(mask) > 1) m_conflict = 1'b1;
            m_winner = 3'(win);
            last_k = d;
        end else begin
            exp_byte  = 8'hFF;
            m_timeout = 1'b1;
            last_k    = TMO - 1;
        end
        opcode_in = op;
        opcode_valid_in = 1'b1;
        response_valid_in = '0;
        response_in = $urandom;
        tick();
        early = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (k == d) begin
                response_valid_in = mask;
                response_in = data;
            end else begin
                response_in = $urandom;
            end
            if (response_valid_out) early = 1'b1;
            tick();
        end
        n_checks++;
        if (early !== 1'b0) $display("FAIL %s early_valid: got 1 want 0", name);
        else n_pass++;
        n_checks++;
        if (response_valid_out !== 1'b1) $display("FAIL %s valid: got %b want 1", name, response_valid_out);
        else n_pass++;
        n_checks++;
        if (response_out !== exp_byte) $display("FAIL %s data: got %h want %h", name, response_out, exp_byte);
        else n_pass++;
        n_checks++;
        if ({conflict_out, timeout_out} !== {m_conflict, m_timeout})
            $display("FAIL %s flags: got c=%b t=%b want c=%b t=%b", name, conflict_out, timeout_out, m_conflict, m_timeout);
        else n_pass++;
        hold_bad = 1'b0;
        for (int h = 0; h < 2; h++) begin
            response_in = $urandom;
            response_valid_in = NR'($urandom);
            tick();
            if (response_valid_out !== 1'b1 || response_out !== exp_byte) hold_bad = 1'b1;
        end
        n_checks++;
        if (hold_bad !== 1'b0) $display("FAIL %s hold: got %h/%b want %h/1", name, response_out, response_valid_out, exp_byte);
        else n_pass++;
        opcode_valid_in = 1'b0;
        response_valid_in = '0;
        tick();
        n_checks++;
        if ({response_valid_out, response_out} !== 9'h000)
            $display("FAIL %s release: got %b/%h want 0/00", name, response_valid_out, response_out);
        else n_pass++;
    endtask

    task automatic status_read(input string name);
        logic [7:0] exp_byte;
        exp_byte = {m_conflict, m_timeout, 3'b000, m_winner};
        m_conflict = 1'b0;
        m_timeout  = 1'b0;
        opcode_in = 8'hDF;
        opcode_valid_in = 1'b1;
        response_valid_in = NR'($urandom);
        tick();
        n_checks++;
        if ({response_valid_out, response_out} !== {1'b1, exp_byte})
            $display("FAIL %s status: got %b/%h want 1/%h", name, response_valid_out, response_out, exp_byte);
        else n_pass++;
        n_checks++;
        if ({conflict_out, timeout_out} !== 2'b00)
            $display("FAIL %s status_clear: got c=%b t=%b want 0 0", name, conflict_out, timeout_out);
        else n_pass++;
        opcode_valid_in = 1'b0;
        response_valid_in = '0;
        tick();
        n_checks++;
        if (response_valid_out !== 1'b0) $display("FAIL %s status_release: got %b want 0", name, response_valid_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({response_valid_out, response_out, conflict_out, timeout_out} !== 11'h0)
            $display("FAIL reset_state: got v=%b d=%h c=%b t=%b want all 0",
                     response_valid_out, response_out, conflict_out, timeout_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_txn("basic_slot2", 8'hDB, 3, 4'b0100, {8'h3C, 8'h81, 8'h7E, 8'h12});
    endtask

    task automatic test_conflict();
        run_txn("conflict", 8'h20, 2, 4'b1010, {8'hAA, 8'h11, 8'h55, 8'h22});
        status_read("status_after_conflict");
    endtask

    task automatic test_timeout();
        run_txn("timeout", 8'h10, NONE, 4'b0000, 32'h0);
        status_read("status_after_timeout");
        run_txn("late_data_wins", 8'h10, TMO - 1, 4'b1000, {8'h5A, 8'h00, 8'h00, 8'h00});
    endtask

    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        opcode_in = 8'h31;
        opcode_valid_in = 1'b1;
        response_valid_in = '0;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (response_valid_out) seen = 1'b1;
        end
        opcode_valid_in = 1'b0;
        tick();
        if (response_valid_out) seen = 1'b1;
        tick();
        if (response_valid_out) seen = 1'b1;
        n_checks++;
        if (seen !== 1'b0) $display("FAIL abort_valid: got 1 want 0");
        else n_pass++;
        n_checks++;
        if ({conflict_out, timeout_out} !== {m_conflict, m_timeout})
            $display("FAIL abort_flags: got c=%b t=%b want c=%b t=%b", conflict_out, timeout_out, m_conflict, m_timeout);
        else n_pass++;
        run_txn("after_abort", 8'h32, 1, 4'b0010, {8'h00, 8'h00, 8'hC3, 8'h00});
    endtask

    task automatic test_random();
        int         dsel;
        int         d;
        logic [7:0] op;
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                status_read("rand_status");
            end else begin
                dsel = $urandom_range(0, 9);
                d = (dsel < 7) ? dsel : (dsel == 7) ? TMO - 2 : (dsel == 8) ? TMO - 1 : NONE;
                op = 8'($urandom);
                if (op == 8'hDF) op = 8'h00;
                run_txn("rand_txn", op, d, NR'($urandom_range(1, 15)), NR*8'($urandom));
            end
        end
    endtask

    task automatic test_reset_release();
        bit seen;
        seen = 1'b0;
        rst_n = 1'b0;
        opcode_in = 8'h33;
        opcode_valid_in = 1'b1;
        response_valid_in = 4'b0001;
        response_in = 32'h0000_0077;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (response_valid_out) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL reset_release_ignored: got 1 want 0");
        else n_pass++;
        opcode_valid_in = 1'b0;
        response_valid_in = '0;
        tick();
        run_txn("after_release", 8'h33, 0, 4'b0001, 32'h0000_0077);
    endtask

    task automatic test_reset_in_hold();
        opcode_in = 8'h44;
        opcode_valid_in = 1'b1;
        response_valid_in = '0;
        tick();
        response_valid_in = 4'b1010;
        response_in = 32'h9900_6600;
        tick();
        n_checks++;
        if ({response_valid_out, response_out, conflict_out} !== {1'b1, 8'h66, 1'b1})
            $display("FAIL hold_before_reset: got %b/%h c=%b want 1/66 c=1", response_valid_out, response_out, conflict_out);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({response_valid_out, response_out, conflict_out, timeout_out} !== 11'h0)
            $display("FAIL reset_in_hold: got v=%b d=%h c=%b t=%b want all 0",
                     response_valid_out, response_out, conflict_out, timeout_out);
        else n_pass++;
        opcode_valid_in = 1'b0;
        response_valid_in = '0;
        tick();
        rst_n = 1'b1;
        tick();
        status_read("status_after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        opcode_in = 8'h00;
        opcode_valid_in = 1'b0;
        response_in = '0;
        response_valid_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_conflict();
        test_timeout();
        test_abort();
        test_random();
        test_reset_release();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
